// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - data RAM port arbiter, pipeline priority plus secondary req/gnt
// Optional starvation guard: define DMEM_ARB_STARVE_GUARD_EN.
module dmem_port_arbiter #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_wdata,
  input  logic              pipe_write,
  input  logic              pipe_read,
  output logic              pipe_stall,
  output logic [DATA_W-1:0] pipe_rdata,
  input  logic              sec_req,
  input  logic              sec_write,
  input  logic [ADDR_W-1:0] sec_addr,
  input  logic [DATA_W-1:0] sec_wdata,
  output logic              sec_gnt,
  output logic              sec_rvalid,
  output logic [DATA_W-1:0] sec_rdata,
  output logic [ADDR_W-1:0] addr_mem,
  output logic [DATA_W-1:0] wdata_mem,
  output logic              write_mem,
  input  logic [DATA_W-1:0] rdata_mem
);

  logic w_pipe_act;
  logic w_force;
  logic r_sec_rvalid;

  assign w_pipe_act = pipe_read | pipe_write;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] r_wait_cnt;

  // The guard only fires for a request still being held; a dropped request never forces.
  assign w_force = ~rst & sec_req & (r_wait_cnt == WAIT_MAX);

  // Count cycles the secondary has waited, saturating; any grant or release clears it
  always_ff @(posedge clk) begin
    if (rst || !sec_req || sec_gnt) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != WAIT_MAX) begin
      r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end
  end
`else
  // Without the guard the pipeline always wins; MAX_WAIT has no effect.
  assign w_force = 1'b0 & (MAX_WAIT > 0);
`endif

  // Per-cycle port owner select: reset, forced secondary, pipeline, secondary, idle
  always_comb begin
    addr_mem   = pipe_addr;
    wdata_mem  = pipe_wdata;
    write_mem  = 1'b0;
    sec_gnt    = 1'b0;
    pipe_stall = 1'b0;
    if (rst) begin
      write_mem = 1'b0;
    end else if (w_force) begin
      addr_mem   = sec_addr;
      wdata_mem  = sec_wdata;
      write_mem  = sec_write;
      sec_gnt    = 1'b1;
      pipe_stall = 1'b1;
    end else if (w_pipe_act) begin
      // read and write together behave as a write
      write_mem = pipe_write;
    end else if (sec_req) begin
      addr_mem  = sec_addr;
      wdata_mem = sec_wdata;
      write_mem = sec_write;
      sec_gnt   = 1'b1;
    end
  end

  // Secondary read data arrives one cycle after its grant, matching the RAM read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sec_rvalid <= 1'b0;
    end else begin
      r_sec_rvalid <= sec_gnt & ~sec_write;
    end
  end

  assign sec_rvalid = r_sec_rvalid;
  assign sec_rdata  = r_sec_rvalid ? rdata_mem : '0;
  assign pipe_rdata = rdata_mem;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - self-checking bench for dmem_port_arbiter
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  pipe_addr;
  logic [15:0] pipe_wdata;
  logic        pipe_write;
  logic        pipe_read;
  logic        pipe_stall;
  logic [15:0] pipe_rdata;
  logic        sec_req;
  logic        sec_write;
  logic [8:0]  sec_addr;
  logic [15:0] sec_wdata;
  logic        sec_gnt;
  logic        sec_rvalid;
  logic [15:0] sec_rdata;
  logic [8:0]  addr_mem;
  logic [15:0] wdata_mem;
  logic        write_mem;
  logic [15:0] rdata_mem;

  logic [15:0] ram [512];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.ADDR_W(9), .DATA_W(16), .MAX_WAIT(8)) dut (
    .clk(clk), .rst(rst),
    .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata), .pipe_write(pipe_write),
    .pipe_read(pipe_read), .pipe_stall(pipe_stall), .pipe_rdata(pipe_rdata),
    .sec_req(sec_req), .sec_write(sec_write), .sec_addr(sec_addr),
    .sec_wdata(sec_wdata), .sec_gnt(sec_gnt), .sec_rvalid(sec_rvalid),
    .sec_rdata(sec_rdata), .addr_mem(addr_mem), .wdata_mem(wdata_mem),
    .write_mem(write_mem), .rdata_mem(rdata_mem)
  );

  // Synchronous-read RAM: read returns the contents before this edge's write
  always @(posedge clk) begin
    if (write_mem) ram[addr_mem] <= wdata_mem;
    rdata_mem <= ram[addr_mem];
  end

  typedef struct {
    logic [8:0]  pa;
    logic [15:0] pwd;
    logic        pw;
    logic        pr;
    logic        sr;
    logic        sw;
    logic [8:0]  sa;
    logic [15:0] swd;
    logic        e_gnt;
    logic        e_wm;
    logic [8:0]  e_addr;
    logic [15:0] e_wd;
    logic        e_rv;
    logic        chk_rd;
    logic [15:0] e_rd;
    logic        chk_prd;
    logic [15:0] e_prd;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [8:0] pa, input logic [15:0] pwd, input logic pw,
                       input logic pr, input logic sr, input logic sw,
                       input logic [8:0] sa, input logic [15:0] swd);
    pipe_addr = pa; pipe_wdata = pwd; pipe_write = pw; pipe_read = pr;
    sec_req = sr; sec_write = sw; sec_addr = sa; sec_wdata = swd;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ram[i] = 16'h0000;

    //            pa      pwd      pw pr sr sw sa      swd      gnt wm addr    wd       rv crd rd       cprd prd
    vecs[0]  = '{9'h000, 16'h0000, 0, 0, 1, 1, 9'h1A5, 16'hBEEF, 1, 1, 9'h1A5, 16'hBEEF, 0, 0, 16'h0,    0, 16'h0};
    vecs[1]  = '{9'h000, 16'h0000, 0, 0, 1, 0, 9'h1A5, 16'h0000, 1, 0, 9'h1A5, 16'h0000, 1, 1, 16'hBEEF, 0, 16'h0};
    vecs[2]  = '{9'h010, 16'h1234, 1, 0, 1, 0, 9'h010, 16'h0000, 0, 1, 9'h010, 16'h1234, 0, 0, 16'h0,    0, 16'h0};
    vecs[3]  = '{9'h011, 16'h0000, 0, 0, 1, 0, 9'h010, 16'h0000, 1, 0, 9'h010, 16'h0000, 1, 1, 16'h1234, 0, 16'h0};
    vecs[4]  = '{9'h020, 16'h5A5A, 1, 1, 0, 0, 9'h000, 16'h0000, 0, 1, 9'h020, 16'h5A5A, 0, 0, 16'h0,    0, 16'h0};
    vecs[5]  = '{9'h020, 16'h0000, 0, 1, 0, 0, 9'h000, 16'h0000, 0, 0, 9'h020, 16'h0000, 0, 0, 16'h0,    1, 16'h5A5A};
    vecs[6]  = '{9'h033, 16'h7777, 0, 0, 0, 0, 9'h0AA, 16'h1111, 0, 0, 9'h033, 16'h7777, 0, 0, 16'h0,    0, 16'h0};
    vecs[7]  = '{9'h1A5, 16'h0000, 0, 1, 1, 1, 9'h0AA, 16'hAAAA, 0, 0, 9'h1A5, 16'h0000, 0, 0, 16'h0,    1, 16'hBEEF};
    vecs[8]  = '{9'h044, 16'h0000, 0, 0, 0, 1, 9'h0AA, 16'hAAAA, 0, 0, 9'h044, 16'h0000, 0, 0, 16'h0,    0, 16'h0};
    vecs[9]  = '{9'h000, 16'h0000, 0, 0, 1, 1, 9'h1FF, 16'h0001, 1, 1, 9'h1FF, 16'h0001, 0, 0, 16'h0,    0, 16'h0};
    vecs[10] = '{9'h000, 16'h0000, 0, 0, 1, 0, 9'h1FF, 16'h0000, 1, 0, 9'h1FF, 16'h0000, 1, 1, 16'h0001, 0, 16'h0};
    vecs[11] = '{9'h000, 16'h0000, 0, 0, 1, 0, 9'h0AA, 16'h0000, 1, 0, 9'h0AA, 16'h0000, 1, 1, 16'h0000, 0, 16'h0};

    // reset: a read offered during reset is not granted and yields no rvalid
    rst = 1'b1;
    drive(9'h000, 16'h0000, 0, 0, 1, 0, 9'h1A5, 16'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_gnt_idle", {31'b0, sec_gnt}, 32'd0);
    @(posedge clk); #1;
    chk("rst_rvalid", {31'b0, sec_rvalid}, 32'd0);
    @(negedge clk);
    drive(9'h000, 16'h0000, 1, 0, 1, 0, 9'h1A5, 16'h0);
    #1;
    chk("rst_write_mem", {31'b0, write_mem}, 32'd0);
    chk("rst_gnt", {31'b0, sec_gnt}, 32'd0);
    chk("rst_stall", {31'b0, pipe_stall}, 32'd0);
    @(posedge clk); #1;
    chk("rst_rvalid2", {31'b0, sec_rvalid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(9'h000, 16'h0000, 1, 0, 0, 0, 9'h000, 16'h0);
    #1;
    chk("rel_write_mem", {31'b0, write_mem}, 32'd1);
    @(posedge clk); #1;

    // table-driven single-cycle vectors
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i].pa, vecs[i].pwd, vecs[i].pw, vecs[i].pr,
            vecs[i].sr, vecs[i].sw, vecs[i].sa, vecs[i].swd);
      #1;
      chk($sformatf("v%0d_gnt", i),   {31'b0, sec_gnt},    {31'b0, vecs[i].e_gnt});
      chk($sformatf("v%0d_wm", i),    {31'b0, write_mem},  {31'b0, vecs[i].e_wm});
      chk($sformatf("v%0d_addr", i),  {23'b0, addr_mem},   {23'b0, vecs[i].e_addr});
      chk($sformatf("v%0d_wd", i),    {16'b0, wdata_mem},  {16'b0, vecs[i].e_wd});
      chk($sformatf("v%0d_stall", i), {31'b0, pipe_stall}, 32'd0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_rv", i), {31'b0, sec_rvalid}, {31'b0, vecs[i].e_rv});
      if (vecs[i].chk_rd)
        chk($sformatf("v%0d_srd", i), {16'b0, sec_rdata}, {16'b0, vecs[i].e_rd});
      if (vecs[i].chk_prd)
        chk($sformatf("v%0d_prd", i), {16'b0, pipe_rdata}, {16'b0, vecs[i].e_prd});
    end

`ifdef DMEM_ARB_STARVE_GUARD_EN
    // continuous pipe writes; secondary read forced on its 9th waiting cycle
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      drive(9'h100 + 9'(k), 16'(k), 1, 0, 1, 0, 9'h1A5, 16'h0);
      #1;
      chk($sformatf("g%0d_gnt", k),   {31'b0, sec_gnt},    (k == 9) ? 32'd1 : 32'd0);
      chk($sformatf("g%0d_stall", k), {31'b0, pipe_stall}, (k == 9) ? 32'd1 : 32'd0);
      chk($sformatf("g%0d_wm", k),    {31'b0, write_mem},  (k == 9) ? 32'd0 : 32'd1);
      chk($sformatf("g%0d_addr", k),  {23'b0, addr_mem},   (k == 9) ? 32'h1A5 : 32'h100 + k);
      @(posedge clk); #1;
      chk($sformatf("g%0d_rv", k), {31'b0, sec_rvalid}, (k == 9) ? 32'd1 : 32'd0);
    end
    chk("g_srd", {16'b0, sec_rdata}, 32'hBEEF);
    // held pipe write to 0x109 completes now
    @(negedge clk);
    drive(9'h109, 16'h0009, 1, 0, 0, 0, 9'h000, 16'h0);
    #1;
    chk("g_held_wm", {31'b0, write_mem}, 32'd1);
    chk("g_held_addr", {23'b0, addr_mem}, 32'h109);
    chk("g_held_stall", {31'b0, pipe_stall}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    drive(9'h109, 16'h0000, 0, 1, 0, 0, 9'h000, 16'h0);
    @(posedge clk); #1;
    chk("g_held_data", {16'b0, pipe_rdata}, 32'h0009);
`else
    // without the guard the secondary starves behind continuous pipe writes
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      drive(9'h100 + 9'(k), 16'(k), 1, 0, 1, 0, 9'h1A5, 16'h0);
      #1;
      chk($sformatf("s%0d_gnt", k),   {31'b0, sec_gnt},    32'd0);
      chk($sformatf("s%0d_stall", k), {31'b0, pipe_stall}, 32'd0);
    end
    @(negedge clk);
    drive(9'h000, 16'h0000, 0, 0, 1, 0, 9'h1A5, 16'h0);
    #1;
    chk("s_end_gnt", {31'b0, sec_gnt}, 32'd1);
    @(posedge clk); #1;
    chk("s_end_rd", {16'b0, sec_rdata}, 32'hBEEF);
`endif

    @(negedge clk);
    drive(9'h000, 16'h0000, 0, 0, 0, 0, 9'h000, 16'h0);
    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
